// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//
// Bundles every non-clock signal of pipe_stage_reg. The pipeline register is
// the "slave" side; whatever feeds it and consumes its outputs (the upstream
// stage, the hazard unit, a testbench) uses the "master" side.
//
// Signals (directions as seen from the slave / pipeline register):
//   stall_i       in   hold every stage
//   flush_i       in   bubble every stage (wins over stall_i)
//   valid_in      in   incoming entry is a real instruction
//   data_in       in   DATA_W payload
//   ctrl_in       in   CTRL_W control bits
//   rd_in         in   destination register address
//   rs1_in        in   first source register address
//   rs2_in        in   second source register address
//   valid_out     out  valid bit of the last stage
//   data_out      out  last-stage payload
//   ctrl_out      out  last-stage control bits
//   rd_out        out  last-stage destination address
//   rs1_out       out  last-stage first source address
//   rs2_out       out  last-stage second source address
//   query_addr_i  in   register address checked for pending writes
//   query_hit_o   out  some valid stage will write query_addr_i
//   stall_cnt_o   out  stall-cycle counter
//   flush_cnt_o   out  flush-cycle counter
//   bubble_cnt_o  out  bubble-advance counter
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W     = 96,
    parameter int CTRL_W     = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_W      = 16
);
    logic                  stall_i;
    logic                  flush_i;
    logic                  valid_in;
    logic [DATA_W-1:0]     data_in;
    logic [CTRL_W-1:0]     ctrl_in;
    logic [ADDR_WIDTH-1:0] rd_in;
    logic [ADDR_WIDTH-1:0] rs1_in;
    logic [ADDR_WIDTH-1:0] rs2_in;

    logic                  valid_out;
    logic [DATA_W-1:0]     data_out;
    logic [CTRL_W-1:0]     ctrl_out;
    logic [ADDR_WIDTH-1:0] rd_out;
    logic [ADDR_WIDTH-1:0] rs1_out;
    logic [ADDR_WIDTH-1:0] rs2_out;

    logic [ADDR_WIDTH-1:0] query_addr_i;
    logic                  query_hit_o;

    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;
    logic [CNT_W-1:0]      bubble_cnt_o;

    modport master (
        output stall_i, flush_i, valid_in, data_in, ctrl_in,
               rd_in, rs1_in, rs2_in, query_addr_i,
        input  valid_out, data_out, ctrl_out, rd_out, rs1_out, rs2_out,
               query_hit_o, stall_cnt_o, flush_cnt_o, bubble_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, valid_in, data_in, ctrl_in,
               rd_in, rs1_in, rs2_in, query_addr_i,
        output valid_out, data_out, ctrl_out, rd_out, rs1_out, rs2_out,
               query_hit_o, stall_cnt_o, flush_cnt_o, bubble_cnt_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Multi-stage pipeline register (1..4 stages) carrying a payload, control bits,
// register addresses and a valid bit between two pipeline stages, typically
// Decode -> Execute. With DEPTH=1 and no stalls it behaves exactly like the
// older single-stage ID/EX register.
//
// Per-cycle priority: rst > flush > stall > advance.
//   rst     : every stage cleared, counters cleared.
//   flush   : every stage cleared, the entry on the inputs is dropped.
//   stall   : every stage holds, the inputs are ignored.
//   advance : stage 0 captures the inputs, stage k captures stage k-1.
// An invalid entry always carries ctrl = 0 so downstream logic never acts on
// the control bits of a bubble; data and addresses still pass through.
//
// query_hit_o tells a hazard unit whether any valid stage will write the
// queried register. Register 0 is hard-wired zero and therefore never hits.
//
// Optional feature, selected by defining the macro PIPE_STAGE_PERF_EN:
//   saturating stall / flush / bubble counters. Without the macro the counter
//   registers do not exist and the three counter outputs read 0.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  pipe_stage_reg_if.slave  all data, control, query and counter signals
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W       = 96,
    parameter int CTRL_W       = 16,
    parameter int ADDR_WIDTH   = 5,
    parameter int DEPTH        = 1,
    parameter int REGWRITE_BIT = 0,
    parameter int CNT_W        = 16
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_reg_if.slave bus
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH=%0d is outside the legal range 1..4", DEPTH);
    end

    if (REGWRITE_BIT < 0 || REGWRITE_BIT >= CTRL_W) begin : g_bad_regwrite_bit
        $error("pipe_stage_reg: REGWRITE_BIT=%0d does not fit in CTRL_W=%0d",
               REGWRITE_BIT, CTRL_W);
    end

    // -------------------------------------------------------------------------
    // Stage storage; index 0 is the stage nearest the inputs
    // -------------------------------------------------------------------------
    logic                  r_valid [DEPTH];
    logic [DATA_W-1:0]     r_data  [DEPTH];
    logic [CTRL_W-1:0]     r_ctrl  [DEPTH];
    logic [ADDR_WIDTH-1:0] r_rd    [DEPTH];
    logic [ADDR_WIDTH-1:0] r_rs1   [DEPTH];
    logic [ADDR_WIDTH-1:0] r_rs2   [DEPTH];

    logic w_advance;
    assign w_advance = !bus.flush_i && !bus.stall_i;

    // NOTE: all state uses non-blocking assignments so every stage samples the
    // value its predecessor held before the edge; blocking assignments here
    // would let one entry race through several stages in a single cycle.
    // NOTE: these arrays are at most four entries of flops, not a RAM, so
    // clearing every element on reset/flush is cheap and keeps the hazard
    // query from seeing stale valid bits.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_ctrl[k]  <= '0;
                r_rd[k]    <= '0;
                r_rs1[k]   <= '0;
                r_rs2[k]   <= '0;
            end
        end else if (w_advance) begin
            r_valid[0] <= bus.valid_in;
            r_data[0]  <= bus.data_in;
            r_ctrl[0]  <= bus.ctrl_in & {CTRL_W{bus.valid_in}};
            r_rd[0]    <= bus.rd_in;
            r_rs1[0]   <= bus.rs1_in;
            r_rs2[0]   <= bus.rs2_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
                r_ctrl[k]  <= r_ctrl[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_rs1[k]   <= r_rs1[k-1];
                r_rs2[k]   <= r_rs2[k-1];
            end
        end
        // stall: every stage keeps its value
    end

    assign bus.valid_out = r_valid[DEPTH-1];
    assign bus.data_out  = r_data[DEPTH-1];
    assign bus.ctrl_out  = r_ctrl[DEPTH-1];
    assign bus.rd_out    = r_rd[DEPTH-1];
    assign bus.rs1_out   = r_rs1[DEPTH-1];
    assign bus.rs2_out   = r_rs2[DEPTH-1];

    // -------------------------------------------------------------------------
    // Pending-destination query: looks only at registered contents, never at
    // the entry currently on the inputs.
    // -------------------------------------------------------------------------
    logic w_any_writer;

    // NOTE: w_any_writer gets its default before the loop, so every path through
    // this block assigns it and no latch is inferred.
    always_comb begin
        w_any_writer = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[k] && r_ctrl[k][REGWRITE_BIT] && (r_rd[k] == bus.query_addr_i)) begin
                w_any_writer = 1'b1;
            end
        end
    end

    assign bus.query_hit_o = w_any_writer && (bus.query_addr_i != '0);

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Counters only clear on rst; a flush is itself an event being counted.
    // Each one stops at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (bus.flush_i && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (!bus.flush_i && bus.stall_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_advance && !bus.valid_in && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign bus.stall_cnt_o  = r_stall_cnt;
    assign bus.flush_cnt_o  = r_flush_cnt;
    assign bus.bubble_cnt_o = r_bubble_cnt;
`else
    assign bus.stall_cnt_o  = '0;
    assign bus.flush_cnt_o  = '0;
    assign bus.bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Scoreboard bench for pipe_stage_reg (DEPTH=3, CNT_W=4 so counter saturation
// is reachable). The driver issues one action per cycle and, for every entry
// that really enters the pipeline, pushes its expected appearance at the output
// into exp_q. A separate monitor observes each clock edge, pops the entry that
// must emerge after DEPTH advances, and compares outputs, the hazard query and
// the counters against its own bookkeeping.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W  = 96;
    localparam int CTRL_W  = 16;
    localparam int AW      = 5;
    localparam int DEPTH   = 3;
    localparam int RW_BIT  = 0;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [AW-1:0]     rd;
        logic [AW-1:0]     rs1;
        logic [AW-1:0]     rs2;
    } entry_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_WIDTH(AW), .CNT_W(CNT_W)) bus ();

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .REGWRITE_BIT(RW_BIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    entry_t exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver: present one cycle's inputs and record what the model expects
    // -------------------------------------------------------------------------
    task automatic step(input logic r, input logic f, input logic s, input logic v,
                        input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [AW-1:0] q);
        entry_t e;
        rst              = r;
        bus.flush_i      = f;
        bus.stall_i      = s;
        bus.valid_in     = v;
        bus.data_in      = d;
        bus.ctrl_in      = c;
        bus.rd_in        = rd;
        bus.rs1_in       = rs1;
        bus.rs2_in       = rs2;
        bus.query_addr_i = q;
        if (r || f) begin
            exp_q.delete();            // everything in flight is discarded
        end else if (!s) begin
            e.valid = v;
            e.data  = d;
            e.ctrl  = v ? c : '0;      // bubbles never carry control bits
            e.rd    = rd;
            e.rs1   = rs1;
            e.rs2   = rs2;
            exp_q.push_back(e);
        end
        @(negedge clk);
        #1;
    endtask

    // Plain advance of one entry, query held at q
    task automatic adv(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic [AW-1:0] rd, input logic [AW-1:0] q);
        step(1'b0, 1'b0, 1'b0, v, d, c, rd, 5'd1, 5'd2, q);
    endtask

    task automatic hold(input logic [AW-1:0] q);
        step(1'b0, 1'b0, 1'b1, 1'b1, 96'hDEAD, 16'hFFFF, 5'd9, 5'd9, 5'd9, q);
    endtask

    // -------------------------------------------------------------------------
    // Monitor: observe what happened at each edge, compare after it settles
    // -------------------------------------------------------------------------
    function automatic int sat_inc(input int x);
        return (x >= CNT_MAX) ? CNT_MAX : x + 1;
    endfunction

    function automatic bit writes(input entry_t e, input logic [AW-1:0] q);
        return e.valid && e.ctrl[RW_BIT] && (e.rd == q);
    endfunction

    initial begin
        entry_t last;       // entry currently at the output
        int     fill;       // advances since the last reset/flush, capped at DEPTH
        int     sc, fc, bc;
        logic   r_s, f_s, s_s, v_s;
        entry_t act;
        bit     hit;
        last = '0;
        fill = 0;
        sc = 0; fc = 0; bc = 0;
        forever begin
            @(posedge clk);
            r_s = rst;
            f_s = bus.flush_i;
            s_s = bus.stall_i;
            v_s = bus.valid_in;
            @(negedge clk);
            if (r_s) begin
                last = '0; fill = 0; sc = 0; fc = 0; bc = 0;
            end else if (f_s) begin
                last = '0; fill = 0; fc = sat_inc(fc);
            end else if (s_s) begin
                sc = sat_inc(sc);
            end else begin
                if (!v_s) bc = sat_inc(bc);
                if (fill < DEPTH) fill++;
                if (fill >= DEPTH) begin
                    if (exp_q.size() > 0) begin
                        last = exp_q.pop_front();
                    end else begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL scoreboard: got empty queue expected an entry (t=%0t)", $time);
                    end
                end
            end

            act = {bus.valid_out, bus.data_out, bus.ctrl_out, bus.rd_out, bus.rs1_out, bus.rs2_out};
            check("stage_out", act, last);

            // Registered contents are the output entry plus the queued ones.
            hit = writes(last, bus.query_addr_i);
            foreach (exp_q[i]) if (writes(exp_q[i], bus.query_addr_i)) hit = 1'b1;
            if (bus.query_addr_i == '0) hit = 1'b0;
            check("query_hit", 128'(bus.query_hit_o), 128'(hit));

            check("stall_cnt",  128'(bus.stall_cnt_o),  PERF_EN ? 128'(sc) : 128'(0));
            check("flush_cnt",  128'(bus.flush_cnt_o),  PERF_EN ? 128'(fc) : 128'(0));
            check("bubble_cnt", 128'(bus.bubble_cnt_o), PERF_EN ? 128'(bc) : 128'(0));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        // Reset with every input non-zero; outputs must still read zero.
        step(1'b1, 1'b0, 1'b0, 1'b1, {3{32'hA5A5_5A5A}}, 16'hFFFF, 5'd5, 5'd6, 5'd7, 5'd5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 96'h1234, 16'hFFFF, 5'd5, 5'd6, 5'd7, 5'd5);

        // Latency: A, B, C appear on the third, fourth and fifth advance.
        adv(1'b1, 96'h11, 16'h0001, 5'd1, 5'd1);
        adv(1'b1, 96'h22, 16'h0001, 5'd2, 5'd2);
        adv(1'b1, 96'h33, 16'h0001, 5'd3, 5'd3);
        adv(1'b1, 96'h44, 16'h0000, 5'd4, 5'd4);
        adv(1'b1, 96'h55, 16'h0000, 5'd5, 5'd5);

        // Stall two cycles, then stall and flush together.
        hold(5'd4);
        hold(5'd5);
        step(1'b0, 1'b1, 1'b1, 1'b1, 96'h66, 16'h0001, 5'd6, 5'd0, 5'd0, 5'd6);

        // Bubble gating: control is stripped, data passes through.
        adv(1'b0, 96'hABC, 16'hFFFF, 5'd3, 5'd3);
        adv(1'b0, 96'h0, 16'h0, 5'd0, 5'd3);
        adv(1'b0, 96'h0, 16'h0, 5'd0, 5'd3);

        // Query: rd=7 without regwrite, rd=5 with regwrite, rd=0 with regwrite.
        adv(1'b1, 96'h70, 16'h0000, 5'd7, 5'd7);
        adv(1'b1, 96'h50, 16'h0001, 5'd5, 5'd5);
        adv(1'b1, 96'h00, 16'h0001, 5'd0, 5'd0);
        hold(5'd5);
        hold(5'd7);
        hold(5'd0);
        hold(5'd3);

        // Long stall: counter saturates at its maximum.
        for (int i = 0; i < 20; i++) hold(5'(i % 8));

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            automatic int roll = $urandom_range(99);
            automatic logic r = (roll < 2);
            automatic logic f = (roll >= 2 && roll < 6);
            automatic logic s = (roll >= 6 && roll < 22) || ($urandom_range(99) < 4);
            automatic logic v = ($urandom_range(99) < 70);
            automatic logic [DATA_W-1:0] d = {$urandom, $urandom, $urandom};
            automatic logic [CTRL_W-1:0] c = 16'($urandom);
            step(r, f, s, v, d, c, 5'($urandom_range(7)), 5'($urandom), 5'($urandom),
                 5'($urandom_range(7)));
        end

        // Drain with bubbles so the last entries reach the output.
        for (int i = 0; i < DEPTH + 2; i++) adv(1'b0, 96'h0, 16'h0, 5'd0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised multi-stage pipeline register carrying payload, control, register addresses and a valid bit.
- Successor to the single-stage ID/EX register; sits between any two pipeline stages, typically Decode->Execute.
- Adds configurable depth, a stall (hold) input, valid-qualified control, and a pending-destination query port for hazard units.
- Optional saturating performance counters.

Parameters:
- DATA_W, 96, payload width (e.g. pc, data1, data2 concatenated); zeroed on flush.
- CTRL_W, 16, control-bit width; forced to zero whenever the stage is invalid.
- ADDR_WIDTH, 5, register address width.
- DEPTH, 1, number of register stages, legal range 1..4.
- REGWRITE_BIT, 0, index in the ctrl vector that marks a register write.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- stall_i  in  1  hold all stages
- flush_i  in  1  bubble all stages; priority over stall_i
- valid_in  in  1  incoming entry is a real instruction
- data_in  in  DATA_W  payload
- ctrl_in  in  CTRL_W  control bits
- rd_in / rs1_in / rs2_in  in  ADDR_WIDTH each  destination and source addresses
- valid_out  out  1  valid of last stage
- data_out  out  DATA_W  last-stage payload
- ctrl_out  out  CTRL_W  last-stage control
- rd_out / rs1_out / rs2_out  out  ADDR_WIDTH each  last-stage addresses
- query_addr_i  in  ADDR_WIDTH  address to check for pending writes
- query_hit_o  out  1  some valid stage writes query_addr_i
- stall_cnt_o / flush_cnt_o / bubble_cnt_o  out  CNT_W each  performance counters

Behaviour:
- Clocking and reset: single clock. Reset is synchronous, active-high, on clk rising edge.
- Per-clock priority is rst > flush_i > stall_i > advance.
- rst: every stage's valid, data, ctrl and addresses go to 0. All outputs read 0 in the cycle after rst is sampled. Counters clear to 0.
- flush_i=1: every stage is zeroed exactly as on reset, except the counters.
  - stall_i is ignored that cycle.
  - The entry presented on the inputs that cycle is discarded.
- stall_i=1, flush_i=0: all stages hold their values; inputs are ignored.
- Advance (neither asserted):
  - Stage 0 captures {valid_in, data_in, ctrl_in & {CTRL_W{valid_in}}, rd_in, rs1_in, rs2_in}.
  - Stage k captures stage k-1.
- Control gating: an invalid entry always carries ctrl=0. Data and addresses pass through unchanged unless flushed.
- Latency: input to output is exactly DEPTH cycles of non-stalled advance. With DEPTH=1 and no stall, behaviour matches the legacy single-stage ID/EX register.
- query_hit_o is combinational. It is 1 iff all of the following hold for some stage k:
  - valid[k]=1;
  - ctrl[k][REGWRITE_BIT]=1;
  - rd[k]==query_addr_i;
  - query_addr_i!=0.
- Address 0 never hits.
- Query reflects current register contents only, not the inputs.
- Illegal DEPTH (0 or >4) must cause an elaboration error.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: counters are active and saturate at all-ones (no wrap); all clear on rst.
  - stall_cnt_o increments on each cycle with stall_i=1 and flush_i=0.
  - flush_cnt_o increments on each cycle with flush_i=1.
  - bubble_cnt_o increments on each advance cycle with valid_in=0.
- Undefined: counter registers are not generated and all three outputs are tied to 0.

Test Plan:
- Reset, DEPTH=1: drive inputs non-zero with rst=1 for 1 cycle -> all outputs 0 after the edge, query_hit_o=0 for any query_addr_i.
- Latency, DEPTH=3: feed valid entries A, B, C with data=0x11, 0x22, 0x33 on consecutive cycles -> data_out shows 0x11, 0x22, 0x33 on cycles 3, 4, 5, valid_out=1.
- Stall then flush, DEPTH=2: load A, stall 2 cycles -> outputs frozen. Assert stall_i and flush_i together -> all outputs 0, valid_out=0. With PIPE_STAGE_PERF_EN defined: stall_cnt_o=2, flush_cnt_o=1.
- Bubble gating: valid_in=0, ctrl_in=0xFFFF, data_in=0xABC -> ctrl_out=0, data_out=0xABC, valid_out=0. With PIPE_STAGE_PERF_EN defined: bubble_cnt_o=1.
- Query, DEPTH=2: stage0 holds rd=5 with REGWRITE set; stage1 holds rd=7 with REGWRITE clear.
  - query 5 -> 1
  - query 7 -> 0
  - entry rd=0 with REGWRITE set, query 0 -> 0
- Saturation, CNT_W=4, PIPE_STAGE_PERF_EN defined: hold stall_i for 20 cycles -> stall_cnt_o stays at 15.
